pipeline_debug_controller: RTL
==============================

# pipeline_debug_controller

Sequencing and arbitration block for the 5-stage MIPS pipeline. It gates pipeline advance (run / single-step / halt-drain) from a byte-oriented debug command interface. It also shares register-file read port 1 between the decode stage and a debug dump engine that streams all registers out as bytes. It sits between the debug UART front end and the pipeline stage registers, and its `o_dbg_rd_sel` output drives the read-address mux in front of the register bank.

## Interface
- `NB_DATA`, 32, register width (multiple of 8)
- `NB_REG_ADDR`, 5, register address width
- `N_REGS`, 32, registers dumped
- `PIPE_DEPTH`, 5, stage count; drain length is `PIPE_DEPTH-2` cycles (EX, MEM, WB)
- `i_clk` in 1: single clock, rising edge
- `i_reset` in 1: asynchronous, active-low reset
- `i_cmd_valid` in 1: command strobe
- `i_cmd` in 2: 00 NOP, 01 RUN, 10 STEP, 11 DUMP
- `o_cmd_ready` out 1: command accepted when valid&ready
- `i_halt_detected` in 1: ID stage holds the HALT opcode
- `o_pipe_enable` out 1: all stage registers and PC advance
- `o_fetch_enable` out 1: IF may issue; when 0, IF holds PC and ID injects a bubble
- `o_dbg_rd_sel` out 1: 1 = read port 1 address comes from `o_dbg_rd_addr`
- `o_dbg_rd_addr` out NB_REG_ADDR: dump register index
- `i_dbg_rd_data` in NB_DATA: read port 1 data (combinational)
- `o_tx_valid` out 1, `i_tx_ready` in 1, `o_tx_data` out 8: byte stream to the transmitter
- `o_halted` out 1: program has reached HALT and the pipeline is drained

## Operation
- States: IDLE, RUN, STEP, DRAIN, HALTED, DUMP_RD, DUMP_TX.
- `o_cmd_ready` = 1 only in IDLE and HALTED.
- `o_pipe_enable` = 1 in RUN, STEP, and DRAIN.
- `o_fetch_enable` = 1 in RUN and STEP.
- IDLE transitions: RUN→RUN; STEP→STEP; DUMP→DUMP_RD with index 0; NOP→no change.
- RUN: stays in RUN until `i_halt_detected`=1 is sampled, then goes to DRAIN with the drain counter set to `PIPE_DEPTH-2`.
- STEP: lasts one cycle. Goes to IDLE, or to DRAIN if `i_halt_detected`=1 in that cycle.
- DRAIN: the counter decrements each cycle and the state goes to HALTED at 0. `i_halt_detected` is ignored in DRAIN.
- HALTED: `o_halted`=1 until reset. DUMP is serviced. RUN, STEP, and NOP are accepted and dropped.
- DUMP_RD (1 cycle): `o_dbg_rd_sel`=1. The block captures `i_dbg_rd_data` into a shift register and clears the byte counter, then goes to DUMP_TX.
- DUMP_TX: presents the captured word LSB byte first, NB_DATA/8 bytes per word. It advances on valid&ready.
  - After the last byte: if the index < N_REGS-1, increment the index and go to DUMP_RD.
  - Otherwise go to HALTED if the halted flag is set, else IDLE.
- `o_dbg_rd_sel` stays 1 through all of DUMP_RD and DUMP_TX. The pipeline is frozen throughout the dump.
- `o_dbg_rd_addr` = index register in DUMP_RD and DUMP_TX, 0 otherwise.

## Timing
- Reset values: state IDLE; `o_cmd_ready`=1; `o_pipe_enable`, `o_fetch_enable`, `o_dbg_rd_sel`, `o_tx_valid`, `o_halted`=0; `o_dbg_rd_addr`=0; `o_tx_data`=0; all counters 0.
- Command latency:
  - A command accepted at edge N changes state at edge N. Its effect (e.g. `o_pipe_enable`) is visible in cycle N+1.
  - STEP gives exactly one `o_pipe_enable` cycle.
- Halt latency: `i_halt_detected` sampled at edge N means DRAIN runs cycles N+1..N+PIPE_DEPTH-2 with `o_fetch_enable`=0, and `o_halted`=1 from the following cycle.
- Handshake: `o_tx_valid` and `o_tx_data` are registered. `o_tx_data` holds stable while valid&!ready. `o_tx_valid` drops one cycle after the last handshake and stays 0 during each DUMP_RD.
- Dump length: N_REGS·(NB_DATA/8) bytes, minimum N_REGS·(NB_DATA/8+1) cycles at `i_tx_ready`=1.
- `i_tx_ready` while `o_tx_valid`=0 is ignored. `i_cmd_valid` while `o_cmd_ready`=0 is ignored (not queued).
- Reset asserted mid-dump or mid-drain aborts immediately and all outputs return to reset values asynchronously.

## Configuration
- `PIPE_CTRL_CYCLE_COUNT_EN` defined:
  - Adds a 32-bit counter of `o_pipe_enable` cycles (wraps at 2^32, cleared only by reset).
  - Exposes it as output `o_cycle_count` [31:0].
  - Appends it to every dump as 4 extra bytes, LSB first, after the last register.
- Undefined: no counter and no port; a dump is exactly N_REGS·(NB_DATA/8) bytes.

## Test plan
- Reset, then STEP ×3 with no halt → exactly 3 isolated `o_pipe_enable` pulses, each one cycle after acceptance; state back in IDLE, `o_cmd_ready`=1.
- RUN, then `i_halt_detected` pulse at cycle 10 → `o_fetch_enable` low from cycle 11, `o_pipe_enable` high through cycle 13, `o_halted`=1 from 14; a later RUN is dropped.
- Registers preloaded with R[k]=0xA0B0C000+k, DUMP with `i_tx_ready`=1 → 128 bytes; first bytes 00,C0,B0,A0; last bytes 1F,C0,B0,A0; `o_dbg_rd_sel`=1 throughout.
- DUMP with `i_tx_ready` toggling 1/0 every cycle → byte sequence identical to the previous test, with no duplicates and no drops.
- STEP while `i_halt_detected`=1 → DRAIN entered; `o_halted`=1 after 3 enable cycles; reset during a subsequent dump → `o_tx_valid`=0 immediately and state is IDLE.
- With `PIPE_CTRL_CYCLE_COUNT_EN` defined: 7 STEPs then DUMP → 132 bytes, last four 07,00,00,00.

Source files
------------

// File: rtl/pipeline_debug_controller_if.sv
// Debug command and transmit byte-stream handshake bundle for pipeline_debug_controller.
// The master side is the UART front end; the slave side is the controller.
interface pipeline_debug_controller_if;
  logic       i_cmd_valid;
  logic [1:0] i_cmd;
  logic       o_cmd_ready;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic [7:0] o_tx_data;

  modport master (
    output i_cmd_valid, i_cmd, i_tx_ready,
    input  o_cmd_ready, o_tx_valid, o_tx_data
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_tx_ready,
    output o_cmd_ready, o_tx_valid, o_tx_data
  );
endinterface

// File: rtl/pipeline_debug_controller.sv
// Pipeline run/step/halt-drain sequencer with a register-file dump engine on read port 1.
// Optional PIPE_CTRL_CYCLE_COUNT_EN adds an enable-cycle counter appended to every dump.
module pipeline_debug_controller #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int N_REGS      = 32,
  parameter int PIPE_DEPTH  = 5
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  pipeline_debug_controller_if.slave dbg_bus,
  input  logic                       i_halt_detected,
  output logic                       o_pipe_enable,
  output logic                       o_fetch_enable,
  output logic                       o_dbg_rd_sel,
  output logic [NB_REG_ADDR-1:0]     o_dbg_rd_addr,
  input  logic [NB_DATA-1:0]         i_dbg_rd_data,
  output logic                       o_halted
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
  ,
  output logic [31:0]                o_cycle_count
`endif
);

  localparam int NB_BYTES = NB_DATA / 8;
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
  localparam int NB_SHIFT = (NB_DATA > 32) ? NB_DATA : 32;
`else
  localparam int NB_SHIFT = NB_DATA;
`endif
  localparam int NB_BCNT  = $clog2(NB_SHIFT / 8 + 1);
  localparam int NB_DCNT  = $clog2(PIPE_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED,
    S_DUMP_RD,
    S_DUMP_TX
  } state_t;

  state_t                 r_state,      w_state;
  logic [NB_DCNT-1:0]     r_drain_cnt,  w_drain_cnt;
  logic [NB_REG_ADDR-1:0] r_idx,        w_idx;
  logic [NB_BCNT-1:0]     r_byte_cnt,   w_byte_cnt;
  logic [NB_SHIFT-1:0]    r_shift,      w_shift;
  logic                   r_tx_valid,   w_tx_valid;
  logic                   r_halted,     w_halted;
  logic                   w_cmd_ready;
  logic                   w_accept;
  logic                   w_tx_fire;
  logic [NB_BCNT-1:0]     w_last_byte;
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
  logic                   r_cnt_phase,  w_cnt_phase;
  logic [31:0]            r_cycle_cnt,  w_cycle_cnt;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_idx       <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_tx_valid  <= 1'b0;
      r_halted    <= 1'b0;
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
      r_cnt_phase <= 1'b0;
      r_cycle_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_drain_cnt <= w_drain_cnt;
      r_idx       <= w_idx;
      r_byte_cnt  <= w_byte_cnt;
      r_shift     <= w_shift;
      r_tx_valid  <= w_tx_valid;
      r_halted    <= w_halted;
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
      r_cnt_phase <= w_cnt_phase;
      r_cycle_cnt <= w_cycle_cnt;
`endif
    end
  end

  always_comb begin
    w_state     = r_state;
    w_drain_cnt = r_drain_cnt;
    w_idx       = r_idx;
    w_byte_cnt  = r_byte_cnt;
    w_shift     = r_shift;
    w_tx_valid  = r_tx_valid;
    w_halted    = r_halted;
    w_cmd_ready = (r_state == S_IDLE) || (r_state == S_HALTED);
    w_accept    = dbg_bus.i_cmd_valid && w_cmd_ready;
    w_tx_fire   = r_tx_valid && dbg_bus.i_tx_ready;
    w_last_byte = NB_BCNT'(NB_BYTES - 1);
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
    w_cnt_phase = r_cnt_phase;
    w_cycle_cnt = r_cycle_cnt + 32'(o_pipe_enable);
    if (r_cnt_phase) w_last_byte = NB_BCNT'(3);
`endif

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (dbg_bus.i_cmd)
            2'b01: w_state = S_RUN;
            2'b10: w_state = S_STEP;
            2'b11: begin
              w_state = S_DUMP_RD;
              w_idx   = '0;
            end
            default: w_state = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (i_halt_detected) begin
          w_state     = S_DRAIN;
          w_drain_cnt = NB_DCNT'(PIPE_DEPTH - 2);
        end
      end
      S_STEP: begin
        if (i_halt_detected) begin
          w_state     = S_DRAIN;
          w_drain_cnt = NB_DCNT'(PIPE_DEPTH - 2);
        end else begin
          w_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        // The counter holds the remaining enable cycles including this one.
        if (r_drain_cnt <= NB_DCNT'(1)) begin
          w_state     = S_HALTED;
          w_drain_cnt = '0;
          w_halted    = 1'b1;
        end else begin
          w_drain_cnt = r_drain_cnt - NB_DCNT'(1);
        end
      end
      S_HALTED: begin
        if (w_accept && (dbg_bus.i_cmd == 2'b11)) begin
          w_state = S_DUMP_RD;
          w_idx   = '0;
        end
      end
      S_DUMP_RD: begin
        w_shift    = NB_SHIFT'(i_dbg_rd_data);
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
        if (r_cnt_phase) w_shift = NB_SHIFT'(r_cycle_cnt);
`endif
        w_byte_cnt = '0;
        w_tx_valid = 1'b1;
        w_state    = S_DUMP_TX;
      end
      S_DUMP_TX: begin
        if (w_tx_fire) begin
          if (r_byte_cnt == w_last_byte) begin
            w_tx_valid = 1'b0;
            if (r_idx < NB_REG_ADDR'(N_REGS - 1)) begin
              w_idx   = r_idx + NB_REG_ADDR'(1);
              w_state = S_DUMP_RD;
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
            end else if (!r_cnt_phase) begin
              // Counter word rides one extra read/transmit pass after the last register.
              w_cnt_phase = 1'b1;
              w_state     = S_DUMP_RD;
`endif
            end else begin
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
              w_cnt_phase = 1'b0;
`endif
              w_state = r_halted ? S_HALTED : S_IDLE;
            end
          end else begin
            w_byte_cnt = r_byte_cnt + NB_BCNT'(1);
            w_shift    = r_shift >> 8;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign dbg_bus.o_cmd_ready = w_cmd_ready;
  assign dbg_bus.o_tx_valid  = r_tx_valid;
  assign dbg_bus.o_tx_data   = r_shift[7:0];
  assign o_pipe_enable  = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN);
  assign o_fetch_enable = (r_state == S_RUN) || (r_state == S_STEP);
  assign o_dbg_rd_sel   = (r_state == S_DUMP_RD) || (r_state == S_DUMP_TX);
  assign o_dbg_rd_addr  = o_dbg_rd_sel ? r_idx : '0;
  assign o_halted       = r_halted;
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
  assign o_cycle_count  = r_cycle_cnt;
`endif

endmodule
